// File: rtl/sram_ro_bridge.sv
// Wishbone pipelined read-only bridge to a synchronous SRAM read port with fixed read latency.
// Optional data parity check is enabled by defining SRAM_RO_PARITY_EN.
module sram_ro_bridge #(
  parameter int ADDR_WIDTH   = 8,
  parameter int RD_LATENCY   = 1,
  parameter int ERR_ON_WRITE = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  wb_cyc_i,
  input  logic                  wb_stb_i,
  input  logic                  wb_we_i,
  input  logic [31:0]           wb_adr_i,
  input  logic [3:0]            wb_sel_i,
  input  logic [31:0]           wb_dat_i,
  output logic                  wb_ack_o,
  output logic                  wb_err_o,
  output logic                  wb_rty_o,
  output logic                  wb_stall_o,
  output logic [31:0]           wb_dat_o,
  output logic [ADDR_WIDTH-3:0] mem_addr_o,
  output logic                  mem_rd_o,
  input  logic [31:0]           mem_data_i
`ifdef SRAM_RO_PARITY_EN
  ,
  input  logic                  mem_par_i,
  output logic                  par_err_o
`endif
);

  typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

  localparam logic [2:0] LAT_INIT = 3'(RD_LATENCY);
  localparam logic       WR_ERR   = (ERR_ON_WRITE != 0);

  state_t     state;
  logic [2:0] lat_cnt;
  logic       wb_en;
  logic       par_bad;
  logic       unused_inputs;

  assign wb_en      = wb_cyc_i & wb_stb_i;
  assign wb_stall_o = wb_en & (state != IDLE);
  assign wb_rty_o   = 1'b0;

`ifdef SRAM_RO_PARITY_EN
  // Even parity: data bits plus parity bit must hold an even number of ones.
  assign par_bad = (^mem_data_i) != mem_par_i;
`else
  assign par_bad = 1'b0;
`endif

  assign unused_inputs = ^{wb_sel_i, wb_dat_i, wb_adr_i[31:ADDR_WIDTH], wb_adr_i[1:0]};

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      lat_cnt    <= 3'd0;
      wb_ack_o   <= 1'b0;
      wb_err_o   <= 1'b0;
      wb_dat_o   <= 32'd0;
      mem_addr_o <= '0;
      mem_rd_o   <= 1'b0;
`ifdef SRAM_RO_PARITY_EN
      par_err_o  <= 1'b0;
`endif
    end else begin
      wb_ack_o <= 1'b0;
      wb_err_o <= 1'b0;
      mem_rd_o <= 1'b0;
`ifdef SRAM_RO_PARITY_EN
      par_err_o <= 1'b0;
`endif
      case (state)
        IDLE: begin
          if (wb_en) begin
            if (wb_we_i) begin
              state    <= RESP;
              wb_err_o <= WR_ERR;
              wb_ack_o <= ~WR_ERR;
            end else begin
              mem_addr_o <= wb_adr_i[ADDR_WIDTH-1:2];
              mem_rd_o   <= 1'b1;
              lat_cnt    <= LAT_INIT;
              state      <= RD_WAIT;
            end
          end
        end
        RD_WAIT: begin
          // Last count cycle is the one in which the SRAM data is valid.
          if (!wb_cyc_i) begin
            state   <= IDLE;
            lat_cnt <= 3'd0;
          end else if (lat_cnt == 3'd1) begin
            lat_cnt <= 3'd0;
            state   <= RESP;
            if (par_bad) begin
              wb_err_o <= 1'b1;
              wb_dat_o <= 32'd0;
`ifdef SRAM_RO_PARITY_EN
              par_err_o <= 1'b1;
`endif
            end else begin
              wb_ack_o <= 1'b1;
              wb_dat_o <= mem_data_i;
            end
          end else begin
            lat_cnt <= lat_cnt - 3'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ro_bridge.sv
// Directed bench for sram_ro_bridge: three instances (latency 1/4/3) share one bus driver,
// each backed by a latency-accurate SRAM model.
module tb_sram_ro_bridge;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst = 1'b1, cyc = 1'b0, stb = 1'b0, we = 1'b0;
  logic [31:0] adr = 32'd0, wdat = 32'd0;
  logic [3:0]  sel = 4'hF;
  logic        ovr_en = 1'b0, par_flip = 1'b0;
  logic [31:0] ovr_data = 32'd0;

  int checks = 0;
  int failures = 0;

  logic        ack1, err1, rty1, stall1, rd1;
  logic        ack4, err4, rty4, stall4, rd4;
  logic        ack3, err3, rty3, stall3, rd3;
  logic [31:0] dat1, dat4, dat3, md1, md4, md3;
  logic [5:0]  addr1, addr4, addr3;
  logic [3:0]  h1 = '0, h4 = '0, h3 = '0;

  function automatic logic [31:0] mem_word(input logic [5:0] a);
    return (a == 6'h05) ? 32'hDEADBEEF : (32'hC0DE0000 | {26'd0, a});
  endfunction

  function automatic logic [31:0] mem_out(input logic vld, input logic [5:0] a);
    if (!vld) return 32'hBAADF00D;
    return ovr_en ? ovr_data : mem_word(a);
  endfunction

  // SRAM models: data valid RD_LATENCY-1 cycles after the read strobe cycle.
  always @(posedge clk) begin
    h1 <= {h1[2:0], rd1};
    h4 <= {h4[2:0], rd4};
    h3 <= {h3[2:0], rd3};
  end
  assign md1 = mem_out(rd1, addr1);
  assign md4 = mem_out(h4[2], addr4);
  assign md3 = mem_out(h3[1], addr3);

`ifdef SRAM_RO_PARITY_EN
  logic mp1, mp4, mp3, perr1, perr4, perr3;
  assign mp1 = (^md1) ^ par_flip;
  assign mp4 = (^md4) ^ par_flip;
  assign mp3 = (^md3) ^ par_flip;
`endif

  sram_ro_bridge #(.ADDR_WIDTH(8), .RD_LATENCY(1), .ERR_ON_WRITE(1)) d1 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_ack_o(ack1), .wb_err_o(err1),
    .wb_rty_o(rty1), .wb_stall_o(stall1), .wb_dat_o(dat1), .mem_addr_o(addr1),
    .mem_rd_o(rd1), .mem_data_i(md1)
`ifdef SRAM_RO_PARITY_EN
    , .mem_par_i(mp1), .par_err_o(perr1)
`endif
  );

  sram_ro_bridge #(.ADDR_WIDTH(8), .RD_LATENCY(4), .ERR_ON_WRITE(0)) d4 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_ack_o(ack4), .wb_err_o(err4),
    .wb_rty_o(rty4), .wb_stall_o(stall4), .wb_dat_o(dat4), .mem_addr_o(addr4),
    .mem_rd_o(rd4), .mem_data_i(md4)
`ifdef SRAM_RO_PARITY_EN
    , .mem_par_i(mp4), .par_err_o(perr4)
`endif
  );

  sram_ro_bridge #(.ADDR_WIDTH(8), .RD_LATENCY(3), .ERR_ON_WRITE(1)) d3 (
    .clk_i(clk), .rst_i(rst), .wb_cyc_i(cyc), .wb_stb_i(stb), .wb_we_i(we),
    .wb_adr_i(adr), .wb_sel_i(sel), .wb_dat_i(wdat), .wb_ack_o(ack3), .wb_err_o(err3),
    .wb_rty_o(rty3), .wb_stall_o(stall3), .wb_dat_o(dat3), .mem_addr_o(addr3),
    .mem_rd_o(rd3), .mem_data_i(md3)
`ifdef SRAM_RO_PARITY_EN
    , .mem_par_i(mp3), .par_err_o(perr3)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
    next_cycle();
    next_cycle();
    rst = 1'b0;
  endtask

  initial begin
    // Test 1: latency 1 read of word 0x05
    do_reset();
    mid();
    chk("rst_ack", {31'd0, ack1}, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_dat", dat1, 32'd0);
    chk("rst_addr", {26'd0, addr1}, 32'd0);
    chk("rst_rd", {31'd0, rd1}, 32'd0);
    chk("rst_rty", {31'd0, rty1}, 32'd0);
    next_cycle();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14;
    mid();
    chk("l1_stall_T", {31'd0, stall1}, 32'd0);
    next_cycle();
    stb = 1'b0;
    mid();
    chk("l1_addr", {26'd0, addr1}, 32'h05);
    chk("l1_rd_T1", {31'd0, rd1}, 32'd1);
    chk("l1_ack_T1", {31'd0, ack1}, 32'd0);
    next_cycle();
    mid();
    chk("l1_ack_T2", {31'd0, ack1}, 32'd1);
    chk("l1_dat", dat1, 32'hDEADBEEF);
    chk("l1_rd_T2", {31'd0, rd1}, 32'd0);
    chk("l1_err_T2", {31'd0, err1}, 32'd0);
    next_cycle();
    mid();
    chk("l1_ack_T3", {31'd0, ack1}, 32'd0);
    cyc = 1'b0;

    // Test 2: latency 4 read with a second request stalled behind it
    do_reset();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'hFC;
    for (int i = 0; i <= 6; i++) begin
      if (i == 1) adr = 32'h14;
      mid();
      chk($sformatf("l4_stall_T%0d", i), {31'd0, stall4}, {31'd0, (i >= 1 && i <= 5)});
      chk($sformatf("l4_ack_T%0d", i), {31'd0, ack4}, {31'd0, (i == 5)});
      if (i == 1) chk("l4_addr", {26'd0, addr4}, 32'h3F);
      if (i == 5) chk("l4_dat", dat4, 32'hC0DE003F);
      next_cycle();
    end
    stb = 1'b0;
    mid();
    chk("l4_addr2", {26'd0, addr4}, 32'h05);
    chk("l4_rd2", {31'd0, rd4}, 32'd1);
    for (int j = 8; j <= 11; j++) begin
      next_cycle();
      mid();
      chk($sformatf("l4_ack2_T%0d", j), {31'd0, ack4}, {31'd0, (j == 11)});
    end
    chk("l4_dat2", dat4, 32'hDEADBEEF);
    cyc = 1'b0;

    // Test 3: write handling for both ERR_ON_WRITE settings
    do_reset();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14;
    next_cycle();
    stb = 1'b0;
    repeat (6) next_cycle();
    cyc = 1'b0;
    next_cycle();
    next_cycle();
    cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h10; wdat = 32'h12345678;
    mid();
    chk("wr_stall", {31'd0, stall1}, 32'd0);
    next_cycle();
    stb = 1'b0; we = 1'b0;
    mid();
    chk("wr_err1", {31'd0, err1}, 32'd1);
    chk("wr_ack1", {31'd0, ack1}, 32'd0);
    chk("wr_ack4", {31'd0, ack4}, 32'd1);
    chk("wr_err4", {31'd0, err4}, 32'd0);
    chk("wr_rd1", {31'd0, rd1}, 32'd0);
    chk("wr_dat1", dat1, 32'hDEADBEEF);
    chk("wr_dat4", dat4, 32'hDEADBEEF);
    next_cycle();
    mid();
    chk("wr_err1_done", {31'd0, err1}, 32'd0);
    chk("wr_ack4_done", {31'd0, ack4}, 32'd0);
    chk("wr_rd1_done", {31'd0, rd1}, 32'd0);
    cyc = 1'b0;

    // Test 4: latency 3 read aborted by dropping cyc, then a clean read
    do_reset();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h20;
    mid();
    for (int k = 1; k <= 8; k++) begin
      next_cycle();
      if (k == 1) stb = 1'b0;
      if (k == 2) cyc = 1'b0;
      if (k == 4) begin cyc = 1'b1; stb = 1'b1; adr = 32'h14; end
      if (k == 5) stb = 1'b0;
      mid();
      chk($sformatf("ab_ack_T%0d", k), {31'd0, ack3}, {31'd0, (k == 8)});
      chk($sformatf("ab_err_T%0d", k), {31'd0, err3}, 32'd0);
      if (k == 4) chk("ab_stall_T4", {31'd0, stall3}, 32'd0);
      if (k == 5) chk("ab_dat_kept", dat3, 32'd0);
      if (k == 8) chk("ab_dat_new", dat3, 32'hDEADBEEF);
    end
    next_cycle();
    cyc = 1'b0;

    // Test 5: reset asserted while a read is in flight
    next_cycle();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h30;
    mid();
    chk("rm_dat_pre", dat1, 32'hDEADBEEF);
    next_cycle();
    stb = 1'b0; rst = 1'b1;
    mid();
    chk("rm_addr_T1", {26'd0, addr1}, 32'h0C);
    chk("rm_rd_T1", {31'd0, rd1}, 32'd1);
    next_cycle();
    rst = 1'b0;
    mid();
    chk("rm_ack_T2", {31'd0, ack1}, 32'd0);
    chk("rm_err_T2", {31'd0, err1}, 32'd0);
    chk("rm_rd_T2", {31'd0, rd1}, 32'd0);
    chk("rm_addr_T2", {26'd0, addr1}, 32'd0);
    chk("rm_dat_T2", dat1, 32'd0);
    next_cycle();
    cyc = 1'b0;
    mid();
    chk("rm_ack_T3", {31'd0, ack1}, 32'd0);
    chk("rm_err_T3", {31'd0, err1}, 32'd0);

`ifdef SRAM_RO_PARITY_EN
    // Test 6: good-parity read followed by a bad-parity read
    do_reset();
    cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h14;
    next_cycle();
    stb = 1'b0;
    next_cycle();
    mid();
    chk("par_ok_ack", {31'd0, ack1}, 32'd1);
    chk("par_ok_perr", {31'd0, perr1}, 32'd0);
    chk("par_ok_dat", dat1, 32'hDEADBEEF);
    next_cycle();
    cyc = 1'b0;
    next_cycle();
    ovr_en = 1'b1; ovr_data = 32'h00000001; par_flip = 1'b1;
    cyc = 1'b1; stb = 1'b1; adr = 32'h14;
    next_cycle();
    stb = 1'b0;
    next_cycle();
    mid();
    chk("par_bad_err", {31'd0, err1}, 32'd1);
    chk("par_bad_ack", {31'd0, ack1}, 32'd0);
    chk("par_bad_perr", {31'd0, perr1}, 32'd1);
    chk("par_bad_dat", dat1, 32'd0);
    next_cycle();
    mid();
    chk("par_bad_perr_end", {31'd0, perr1}, 32'd0);
    chk("par_bad_err_end", {31'd0, err1}, 32'd0);
    cyc = 1'b0; ovr_en = 1'b0; par_flip = 1'b0;
`endif

    next_cycle();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
